// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and baud divisor.
// Kept separate so the receiver can reuse the same encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with power-of-two depth; the head word is readable combinationally.
// Pushes while full are dropped, pops while empty are ignored; level updates one edge later.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign level_o   = level_q;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter behind a small FIFO; start bit appears one edge after the pop.
// tx_ready drops only when the queue is full; frames run back-to-back while words are queued.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 49152000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [DATA_BITS-1:0]          tx_din,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BPS_CNT = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int CW      = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

  if (BPS_CNT < 2) begin : g_bad_bps
    $error("uart_tx_param: CLK_FREQ/UART_BPS must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 baud_last;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .push_i     (tx_valid),
    .push_dat_i (tx_din),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .level_o    (fifo_level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == PAR_EVEN) ? ^d : ~^d;
  endfunction

  assign baud_last = (baud_q == CW'(BPS_CNT - 1));

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dat;
          par_d    = parity_of(fifo_dat);
          state_d  = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when a word is waiting.
            done_d = 1'b1;
            bit_d  = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dat;
              par_d    = parity_of(fifo_dat);
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PAR:     txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = !fifo_full;
  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter configurations (8N1, 8E1, 8O1, 7N2) run side by side and are compared every
// cycle against a frame-level model: each queued word becomes a list of line bits held BPS cycles.
module tb_uart_tx_param;

  localparam int NDUT  = 4;
  localparam int BPS   = 16;
  localparam int DEPTH = 4;
  localparam int DB  [NDUT] = '{8, 8, 8, 7};
  localparam int PAR [NDUT] = '{0, 2, 1, 0};
  localparam int SB  [NDUT] = '{1, 1, 1, 2};

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] vld   = '0;
  logic [8:0]      din [NDUT];
  logic [NDUT-1:0] rdy, txd, busy, done;
  logic [2:0]      lvl [NDUT];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: queued words, frame in flight (bit list + cycle position), statistics.
  bit [8:0]  mq [NDUT][$];
  bit        m_act [NDUT];
  int        m_pos [NDUT];
  bit [15:0] m_fr [NDUT];
  bit        m_done [NDUT];
  int        m_sent [NDUT];
  int        dut_done_cnt [NDUT];
  bit        m_acc_now, m_last, m_pop;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_param #(
      .CLK_FREQ   (16),
      .UART_BPS   (1),
      .DATA_BITS  (DB[g]),
      .PARITY     (PAR[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DEPTH)
    ) u_dut (
      .sys_clk    (clk),
      .sys_rst_n  (rst_n),
      .tx_din     (din[g][DB[g]-1:0]),
      .tx_valid   (vld[g]),
      .tx_ready   (rdy[g]),
      .uart_txd   (txd[g]),
      .tx_busy    (busy[g]),
      .tx_done    (done[g]),
      .fifo_level (lvl[g])
    );
  end

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d got=%0d want=%0d t=%0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic int frame_bits(input int i);
    return 1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
  endfunction

  // Line bits of one frame, index 0 first on the wire; unused upper bits stay 1 (stop/idle).
  function automatic bit [15:0] frame_of(input int db, input int par, input bit [8:0] w);
    bit [15:0] f;
    int        ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int k = 0; k < db; k++) begin
      f[k+1] = w[k];
      ones  += int'(w[k]);
    end
    if (par == 2)      f[db+1] = ones[0];
    else if (par == 1) f[db+1] = ~ones[0];
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        mq[i].delete();
        m_act[i]  = 1'b0;
        m_pos[i]  = 0;
        m_done[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        m_acc_now = vld[i] && (mq[i].size() < DEPTH);
        m_last    = m_act[i] && (m_pos[i] == frame_bits(i) * BPS - 1);
        m_pop     = (!m_act[i] || m_last) && (mq[i].size() > 0);
        m_done[i] = m_last;
        if (m_last) begin
          m_act[i] = 1'b0;
          m_sent[i]++;
        end else if (m_act[i]) begin
          m_pos[i]++;
        end
        if (m_pop) begin
          m_fr[i]  = frame_of(DB[i], PAR[i], mq[i].pop_front());
          m_pos[i] = 0;
          m_act[i] = 1'b1;
        end
        if (m_acc_now) mq[i].push_back(din[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      chk("uart_txd",   i, int'(txd[i]),  int'(m_act[i] ? m_fr[i][m_pos[i] / BPS] : 1'b1));
      chk("tx_busy",    i, int'(busy[i]), int'(m_act[i]));
      chk("tx_done",    i, int'(done[i]), int'(m_done[i]));
      chk("fifo_level", i, int'(lvl[i]),  mq[i].size());
      chk("tx_ready",   i, int'(rdy[i]),  int'(mq[i].size() < DEPTH));
      if (done[i]) dut_done_cnt[i]++;
    end
  end

  initial begin
    bit [10:0] pat [NDUT];
    int        nb [NDUT], dir_done [NDUT], burst_last [NDUT], rdy_low_exp [NDUT];
    bit        rec [NDUT][200];
    int        first_done [NDUT], n_done [NDUT], last_done [NDUT], max_lvl [NDUT];
    int        n_rdy_low [NDUT], n_gap [NDUT], n_low [NDUT], n_busy [NDUT];
    bit        will_acc [NDUT];
    int        n_stall;

    pat         = '{11'h34A, 11'h54A, 11'h74A, 11'h3AA};
    nb          = '{10, 11, 11, 10};
    dir_done    = '{161, 177, 177, 161};
    burst_last  = '{802, 882, 882, 802};
    rdy_low_exp = '{157, 173, 173, 157};
    for (int i = 0; i < NDUT; i++) din[i] = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_txd",   i, int'(txd[i]),  1);
      chk("rst_ready", i, int'(rdy[i]),  1);
      chk("rst_busy",  i, int'(busy[i]), 0);
      chk("rst_done",  i, int'(done[i]), 0);
      chk("rst_level", i, int'(lvl[i]),  0);
    end
    chk("model_pin_8e1", 1, int'(frame_of(8, 2, 9'h0A5)), 'hFD4A);
    chk("model_pin_8o1", 2, int'(frame_of(8, 1, 9'h0A5)), 'hFF4A);
    chk("model_pin_7n2", 3, int'(frame_of(7, 0, 9'h055)), 'hFFAA);

    // Single word per configuration: bit-centre samples against hand-derived patterns.
    @(negedge clk);
    vld = '1;
    din[0] = 9'h0A5; din[1] = 9'h0A5; din[2] = 9'h0A5; din[3] = 9'h055;
    for (int i = 0; i < NDUT; i++) begin first_done[i] = -1; n_done[i] = 0; end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) vld = '0;
      for (int i = 0; i < NDUT; i++) begin
        rec[i][c] = txd[i];
        if (done[i]) begin
          n_done[i]++;
          if (first_done[i] < 0) first_done[i] = c;
        end
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      chk("idle_at_push_edge", i, int'(rec[i][0]), 1);
      chk("start_latency",     i, int'(rec[i][1]), 0);
      for (int k = 0; k < nb[i]; k++) chk("line_bit", i, int'(rec[i][1 + 16*k + 8]), int'(pat[i][k]));
      chk("done_cycle", i, first_done[i], dir_done[i]);
      chk("done_count", i, n_done[i], 1);
    end

    // Five words on consecutive cycles: contiguous frames, full queue, five done pulses.
    for (int i = 0; i < NDUT; i++) begin
      n_done[i] = 0; last_done[i] = -1; max_lvl[i] = 0; n_rdy_low[i] = 0; n_gap[i] = 0;
    end
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (done[i]) begin n_done[i]++; last_done[i] = c; end
        if (int'(lvl[i]) > max_lvl[i]) max_lvl[i] = int'(lvl[i]);
        if (!rdy[i]) n_rdy_low[i]++;
        if (c >= 2 && !busy[i] && n_done[i] < 5) n_gap[i]++;
        din[i] = 9'($urandom);
      end
      vld = (c < 5) ? {NDUT{1'b1}} : '0;
    end
    for (int i = 0; i < NDUT; i++) begin
      chk("burst_done_count", i, n_done[i], 5);
      chk("burst_last_done",  i, last_done[i], burst_last[i]);
      chk("burst_peak_level", i, max_lvl[i], 4);
      chk("burst_ready_low",  i, n_rdy_low[i], rdy_low_exp[i]);
      chk("burst_idle_gap",   i, n_gap[i], 0);
    end

    // Reset mid-DATA with two words still queued.
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      vld = (c < 3) ? {NDUT{1'b1}} : '0;
      for (int i = 0; i < NDUT; i++) din[i] = 9'($urandom);
    end
    for (int i = 0; i < NDUT; i++) begin
      chk("pre_rst_level", i, int'(lvl[i]),  2);
      chk("pre_rst_busy",  i, int'(busy[i]), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("async_rst_txd",   i, int'(txd[i]),  1);
      chk("async_rst_level", i, int'(lvl[i]),  0);
      chk("async_rst_busy",  i, int'(busy[i]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin n_done[i] = 0; n_low[i] = 0; n_busy[i] = 0; end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (done[i]) n_done[i]++;
        if (!txd[i]) n_low[i]++;
        if (busy[i]) n_busy[i]++;
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      chk("post_rst_done", i, n_done[i], 0);
      chk("post_rst_txd_low", i, n_low[i], 0);
      chk("post_rst_busy", i, n_busy[i], 0);
    end

    // Random traffic: valid held with stable data until the handshake completes.
    n_stall = 0;
    for (int i = 0; i < NDUT; i++) will_acc[i] = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (!vld[i] || will_acc[i]) begin
          vld[i] = ($urandom_range(0, 3) != 0);
          din[i] = 9'($urandom);
        end
        will_acc[i] = vld[i] && rdy[i];
        if (i == 0 && vld[i] && !rdy[i]) n_stall++;
      end
    end
    @(negedge clk);
    vld = '0;
    repeat (1200) @(negedge clk);
    chk("stall_seen", 0, int'(n_stall > 0), 1);
    for (int i = 0; i < NDUT; i++) begin
      chk("total_frames", i, dut_done_cnt[i], m_sent[i]);
      chk("drained_level", i, int'(lvl[i]), 0);
      chk("drained_busy", i, int'(busy[i]), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
